// File: rtl/hazard_if.sv
// ============================================================================
//  Module   : hazard_if
//  Purpose  : Bundle of decode fields, branch/memory status and hazard
//             controls exchanged between the pipeline and hazard_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr;
    logic              id_is_load;
    logic              ex_br_taken;
    logic              mem_busy;
    logic              stall_fe;
    logic              stall_all;
    logic              flush_id;
    logic              bubble_ex;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Pipeline side: supplies decode/status, consumes hazard controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr, id_is_load, ex_br_taken, mem_busy,
        input  stall_fe, stall_all, flush_id, bubble_ex,
               fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr, id_is_load, ex_br_taken, mem_busy,
        output stall_fe, stall_all, flush_id, bubble_ex,
               fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Hazard controller for a 5-stage pipeline. Tracks destination
//             registers in EX/MEM/WB, generates stall/flush/bubble controls
//             and operand-forwarding selects, counts stall and flush cycles.
//  Config   : FORWARDING_EN defined   -> EX/MEM and MEM/WB forwarding,
//                                        one-cycle load-use stall.
//             FORWARDING_EN undefined -> no forwarding; stall on any RAW
//                                        match against EX, MEM or WB.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst_n,
    hazard_if.slave   bus
);

    localparam logic [1:0]       c_FWD_RF  = 2'b00;
    localparam logic [1:0]       c_FWD_MEM = 2'b01;
    localparam logic [1:0]       c_FWD_WB  = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              is_load;
    } entry_t;

    entry_t           r_ex;
    entry_t           r_mem;
    entry_t           r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_m1_ex, w_m2_ex, w_m1_mem, w_m2_mem;
    logic w_hazard;
    logic w_stall_fe, w_stall_all, w_flush_id, w_bubble_ex;
    logic w_inc_stall, w_inc_flush;

    // RAW match of one ID source against one in-flight entry; x0 never matches
    function automatic logic f_match(input entry_t e, input logic vld,
                                     input logic use_s, input logic [REG_AW-1:0] rs);
        return vld & use_s & e.valid & e.wr & (e.rd != '0) & (e.rd == rs);
    endfunction

    assign w_m1_ex  = f_match(r_ex,  bus.id_valid, bus.id_use_rs1, bus.id_rs1);
    assign w_m2_ex  = f_match(r_ex,  bus.id_valid, bus.id_use_rs2, bus.id_rs2);
    assign w_m1_mem = f_match(r_mem, bus.id_valid, bus.id_use_rs1, bus.id_rs1);
    assign w_m2_mem = f_match(r_mem, bus.id_valid, bus.id_use_rs2, bus.id_rs2);

`ifdef FORWARDING_EN
    // WB results reach the regfile before ID reads it, so WB is never a hazard
    logic w_unused_wb;
    assign w_unused_wb = ^r_wb;

    // Only a load still in EX cannot be forwarded in time
    assign w_hazard = (w_m1_ex | w_m2_ex) & r_ex.is_load;
`else
    logic w_m1_wb, w_m2_wb;
    logic w_unused_wb;
    assign w_m1_wb     = f_match(r_wb, bus.id_valid, bus.id_use_rs1, bus.id_rs1);
    assign w_m2_wb     = f_match(r_wb, bus.id_valid, bus.id_use_rs2, bus.id_rs2);
    assign w_unused_wb = r_wb.is_load;

    // Without bypass paths, any pending producer blocks the consumer
    assign w_hazard = w_m1_ex | w_m2_ex | w_m1_mem | w_m2_mem | w_m1_wb | w_m2_wb;
`endif

    // Priority resolution: memory freeze > taken branch > data hazard
    always_comb begin
        w_stall_fe  = 1'b0;
        w_stall_all = 1'b0;
        w_flush_id  = 1'b0;
        w_bubble_ex = 1'b0;
        w_inc_stall = 1'b0;
        w_inc_flush = 1'b0;
        if (!rst_n) begin
            w_stall_fe = 1'b0;
        end else if (bus.mem_busy) begin
            w_stall_all = 1'b1;
            w_stall_fe  = 1'b1;
        end else if (bus.ex_br_taken) begin
            w_flush_id  = 1'b1;
            w_bubble_ex = 1'b1;
            w_inc_flush = 1'b1;
        end else if (w_hazard) begin
            w_stall_fe  = 1'b1;
            w_bubble_ex = 1'b1;
            w_inc_stall = 1'b1;
        end
    end

    // In-flight table advances every unfrozen cycle; a bubble enters EX as invalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!bus.mem_busy) begin
            r_wb          <= r_mem;
            r_mem         <= r_ex;
            r_ex.valid    <= bus.id_valid & ~w_bubble_ex;
            r_ex.rd       <= bus.id_rd;
            r_ex.wr       <= bus.id_wr;
            r_ex.is_load  <= bus.id_is_load;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_inc_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_inc_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

`ifdef FORWARDING_EN
    logic [1:0] r_fwd_sel1;
    logic [1:0] r_fwd_sel2;

    // Select computed as the instruction enters EX; the youngest producer wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_sel1 <= c_FWD_RF;
            r_fwd_sel2 <= c_FWD_RF;
        end else if (!bus.mem_busy) begin
            if (w_bubble_ex) begin
                r_fwd_sel1 <= c_FWD_RF;
                r_fwd_sel2 <= c_FWD_RF;
            end else begin
                r_fwd_sel1 <= w_m1_ex ? c_FWD_MEM : (w_m1_mem ? c_FWD_WB : c_FWD_RF);
                r_fwd_sel2 <= w_m2_ex ? c_FWD_MEM : (w_m2_mem ? c_FWD_WB : c_FWD_RF);
            end
        end
    end

    assign bus.fwd_sel1 = r_fwd_sel1;
    assign bus.fwd_sel2 = r_fwd_sel2;
`else
    assign bus.fwd_sel1 = c_FWD_RF;
    assign bus.fwd_sel2 = c_FWD_RF;
`endif

    assign bus.stall_fe  = w_stall_fe;
    assign bus.stall_all = w_stall_all;
    assign bus.flush_id  = w_flush_id;
    assign bus.bubble_ex = w_bubble_ex;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Self-checking bench for hazard_unit: directed scenarios plus a
//             randomized instruction stream compared against a pipeline
//             model that tracks in-flight producers as simple arrays.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;

    localparam int RAW = 5;
    localparam int CW  = 4;          // narrow counters so saturation is reachable
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    hazard_if #(.REG_AW(RAW), .CNT_W(CW)) hif ();

    hazard_unit #(.REG_AW(RAW), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: in-flight producers, index 0 = EX, 1 = MEM, 2 = WB
    logic           m_v  [3];
    logic [RAW-1:0] m_rd [3];
    logic           m_wr [3];
    logic           m_ld [3];
    int             m_fwd1, m_fwd2, m_scnt, m_fcnt;
    logic           e_sfe, e_fl;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_v[s] = 0; m_rd[s] = '0; m_wr[s] = 0; m_ld[s] = 0;
        end
        m_fwd1 = 0; m_fwd2 = 0; m_scnt = 0; m_fcnt = 0;
        e_sfe = 0; e_fl = 0;
    endtask

    // Does stage s hold a producer of the register the ID instruction reads?
    function automatic bit reads_from(int s, logic use_s, logic [RAW-1:0] rs);
        return hif.id_valid && use_s && m_v[s] && m_wr[s] && m_rd[s] != 0 && m_rd[s] == rs;
    endfunction

    function automatic int fwd_of(logic use_s, logic [RAW-1:0] rs);
        if (reads_from(0, use_s, rs)) return 1;
        if (reads_from(1, use_s, rs)) return 2;
        return 0;
    endfunction

    // One clock: drive ID/status, check at negedge, advance model, pass posedge
    task automatic step(input logic v, input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                        input logic u1, input logic u2, input logic [RAW-1:0] rd,
                        input logic wr, input logic ld, input logic br, input logic busy);
        bit haz, sall, sfe, fl, bub;
        hif.id_valid = v;  hif.id_rs1 = rs1; hif.id_rs2 = rs2;
        hif.id_use_rs1 = u1; hif.id_use_rs2 = u2; hif.id_rd = rd;
        hif.id_wr = wr; hif.id_is_load = ld; hif.ex_br_taken = br; hif.mem_busy = busy;
        @(negedge clk);
`ifdef FORWARDING_EN
        haz = m_ld[0] && (reads_from(0, u1, rs1) || reads_from(0, u2, rs2));
`else
        haz = 0;
        for (int s = 0; s < 3; s++)
            if (reads_from(s, u1, rs1) || reads_from(s, u2, rs2)) haz = 1;
`endif
        sall = busy;
        sfe  = busy || (!br && haz);
        fl   = !busy && br;
        bub  = !busy && (br || haz);
        chk("stall_all", hif.stall_all, sall);
        chk("stall_fe",  hif.stall_fe,  sfe);
        chk("flush_id",  hif.flush_id,  fl);
        chk("bubble_ex", hif.bubble_ex, bub);
        chk("fwd_sel1",  hif.fwd_sel1,  m_fwd1);
        chk("fwd_sel2",  hif.fwd_sel2,  m_fwd2);
        chk("stall_cnt", hif.stall_cnt, m_scnt);
        chk("flush_cnt", hif.flush_cnt, m_fcnt);
        if (!busy) begin
`ifdef FORWARDING_EN
            m_fwd1 = bub ? 0 : fwd_of(u1, rs1);
            m_fwd2 = bub ? 0 : fwd_of(u2, rs2);
`endif
            for (int s = 2; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_wr[s] = m_wr[s-1]; m_ld[s] = m_ld[s-1];
            end
            m_v[0] = v && !bub; m_rd[0] = rd; m_wr[0] = wr; m_ld[0] = ld;
            if (br) m_fcnt = (m_fcnt == CMAX) ? CMAX : m_fcnt + 1;
            else if (haz) m_scnt = (m_scnt == CMAX) ? CMAX : m_scnt + 1;
        end
        e_sfe = sfe; e_fl = fl;
        @(posedge clk);
        #1;
    endtask

    // Instruction shorthands: add rd,rs1,rs2 / lw rd,(rs1) / idle
    task automatic add_i(input logic [RAW-1:0] rd, input logic [RAW-1:0] a,
                         input logic [RAW-1:0] b, input logic br = 0, input logic busy = 0);
        step(1, a, b, 1, 1, rd, 1, 0, br, busy);
    endtask
    task automatic lw_i(input logic [RAW-1:0] rd, input logic [RAW-1:0] a);
        step(1, a, 0, 1, 0, rd, 1, 1, 0, 0);
    endtask
    task automatic nop_i(input logic busy = 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, busy);
    endtask

    task automatic hard_reset();
        rst_n = 0;
        #2;
        rst_n = 1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    int s_before;

    initial begin
        rst_n = 0;
        model_reset();
        hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_use_rs1 = 0;
        hif.id_use_rs2 = 0; hif.id_rd = 0; hif.id_wr = 0; hif.id_is_load = 0;
        hif.ex_br_taken = 0; hif.mem_busy = 0;
        #12;
        chk("rst_stall_fe", hif.stall_fe, 0);
        chk("rst_stall_cnt", hif.stall_cnt, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // 1: back-to-back ALU dependency
        add_i(1, 2, 3);
        add_i(2, 1, 3);
        repeat (4) nop_i();
        // 2: load-use
        lw_i(5, 7);
        add_i(6, 5, 5);
        add_i(6, 5, 5);
        repeat (4) nop_i();
        // 3: x0 producer/consumer
        add_i(0, 1, 2);
        add_i(3, 0, 0);
        repeat (4) nop_i();
        // 4: load-use coincident with taken branch
        hard_reset();
        lw_i(5, 7);
        add_i(6, 5, 5, 1);
        nop_i();
`ifdef FORWARDING_EN
        chk("t4_flush_cnt", hif.flush_cnt, 1);
        chk("t4_stall_cnt", hif.stall_cnt, 0);
`endif
        repeat (3) nop_i();
        // 5: mem_busy freeze in a dependent sequence
        lw_i(8, 1);
        add_i(9, 8, 8, 0, 1);
        add_i(9, 8, 8, 0, 1);
        add_i(9, 8, 8, 0, 1);
        add_i(9, 8, 8);
        add_i(9, 8, 8);
        add_i(10, 9, 8);
        repeat (4) nop_i();
        // 6: reset during a load-use stall, then dependent ALU pair
        lw_i(5, 7);
        hif.id_valid = 1; hif.id_rs1 = 5; hif.id_rs2 = 5; hif.id_use_rs1 = 1;
        hif.id_use_rs2 = 1; hif.id_rd = 6; hif.id_wr = 1; hif.id_is_load = 0;
        #1;
        chk("t6_pre_stall", hif.stall_fe, 1);
        rst_n = 0;
        #1;
        chk("t6_rst_stall_fe", hif.stall_fe, 0);
        chk("t6_rst_bubble", hif.bubble_ex, 0);
        chk("t6_rst_fwd1", hif.fwd_sel1, 0);
        chk("t6_rst_scnt", hif.stall_cnt, 0);
        rst_n = 1;
        model_reset();
        @(posedge clk); #1;
        add_i(1, 2, 3);
        s_before = m_scnt;
        for (int k = 0; k < 6 && (k == 0 || e_sfe); k++) add_i(2, 1, 3);
`ifndef FORWARDING_EN
        chk("t6_three_stalls", hif.stall_cnt, 3);
`else
        chk("t6_no_stall", hif.stall_cnt, 0);
`endif
        chk("t6_model_stalls", m_scnt - s_before, hif.stall_cnt);

        // Randomized stream; ID is held while stalled and cleared after a flush
        begin
            logic v, u1, u2, wr, ld, br, busy;
            logic [RAW-1:0] a, b, d;
            v = 0; u1 = 0; u2 = 0; wr = 0; ld = 0; a = 0; b = 0; d = 0;
            for (int n = 0; n < 600; n++) begin
                if (n % 250 == 249) hard_reset();
                if (!e_sfe) begin
                    v  = e_fl ? 1'b0 : ($urandom_range(0, 9) != 0);
                    a  = RAW'($urandom_range(0, 3));
                    b  = RAW'($urandom_range(0, 3));
                    d  = RAW'($urandom_range(0, 3));
                    u1 = $urandom_range(0, 3) != 0;
                    u2 = $urandom_range(0, 1) != 0;
                    wr = $urandom_range(0, 4) != 0;
                    ld = $urandom_range(0, 2) == 0;
                end
                br   = $urandom_range(0, 11) == 0;
                busy = $urandom_range(0, 7) == 0;
                step(v, a, b, u1, u2, d, wr, ld, br, busy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
